// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing CDB broadcast lanes among execution units
module cdb_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int NUM_LANE = 2,
  parameter int TAG_W    = 3,
  parameter int DATA_W   = 32,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]        req_tag,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]       req_data,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_LANE-1:0]                  lane_valid,
  output logic [NUM_LANE-1:0][TAG_W-1:0]       lane_tag,
  output logic [NUM_LANE-1:0][DATA_W-1:0]      lane_data,
  output logic [NUM_LANE-1:0][SRC_W-1:0]       lane_src,
  output logic                                 dup_tag_err
);

  localparam int IDX_W = SRC_W + 1;
  localparam int CNT_W = $clog2(NUM_LANE + 1);

  logic [SRC_W-1:0]                  r_rr_ptr;
  logic [NUM_LANE-1:0]               r_lane_valid;
  logic [NUM_LANE-1:0][TAG_W-1:0]    r_lane_tag;
  logic [NUM_LANE-1:0][DATA_W-1:0]   r_lane_data;
  logic [NUM_LANE-1:0][SRC_W-1:0]    r_lane_src;
  logic                              r_dup_tag_err;

  logic [NUM_REQ-1:0]                w_grant;
  logic [NUM_LANE-1:0]               w_fill;
  logic [NUM_LANE-1:0][SRC_W-1:0]    w_lane_sel;
  logic [SRC_W-1:0]                  w_next_ptr;
  logic [IDX_W-1:0]                  w_idx;
  logic [CNT_W-1:0]                  w_cnt;
  logic                              w_dup;

  // Scan from r_rr_ptr with wrap; the first NUM_LANE valid requesters win, filling lanes in scan order.
  // Nothing is granted while in reset or during a flush cycle.
  always_comb begin
    w_grant    = '0;
    w_fill     = '0;
    w_lane_sel = '0;
    w_next_ptr = r_rr_ptr;
    w_idx      = '0;
    w_cnt      = '0;
    if (rst && !flush) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        w_idx = IDX_W'(r_rr_ptr) + IDX_W'(j);
        if (w_idx >= IDX_W'(NUM_REQ)) begin
          w_idx = w_idx - IDX_W'(NUM_REQ);
        end
        if (req_valid[w_idx[SRC_W-1:0]] && (w_cnt < CNT_W'(NUM_LANE))) begin
          w_grant[w_idx[SRC_W-1:0]] = 1'b1;
          for (int k = 0; k < NUM_LANE; k++) begin
            if (w_cnt == CNT_W'(k)) begin
              w_fill[k]     = 1'b1;
              w_lane_sel[k] = w_idx[SRC_W-1:0];
            end
          end
          w_cnt      = w_cnt + 1'b1;
          w_next_ptr = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : SRC_W'(w_idx + 1'b1);
        end
      end
    end
  end

  // Flag any pair of same-cycle grants that target the same ROB tag.
  always_comb begin
    w_dup = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = i + 1; j < NUM_REQ; j++) begin
        if (w_grant[i] && w_grant[j] && (req_tag[i] == req_tag[j])) begin
          w_dup = 1'b1;
        end
      end
    end
  end

  // Register granted results onto their lanes, advance the round-robin pointer, latch the duplicate flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr      <= '0;
      r_lane_valid  <= '0;
      r_lane_tag    <= '0;
      r_lane_data   <= '0;
      r_lane_src    <= '0;
      r_dup_tag_err <= 1'b0;
    end else if (flush) begin
      r_rr_ptr     <= '0;
      r_lane_valid <= '0;
    end else begin
      r_lane_valid <= w_fill;
      for (int k = 0; k < NUM_LANE; k++) begin
        if (w_fill[k]) begin
          r_lane_tag[k]  <= req_tag[w_lane_sel[k]];
          r_lane_data[k] <= req_data[w_lane_sel[k]];
          r_lane_src[k]  <= w_lane_sel[k];
        end
      end
      if (|w_grant) begin
        r_rr_ptr <= w_next_ptr;
      end
      if (w_dup) begin
        r_dup_tag_err <= 1'b1;
      end
    end
  end

  assign req_ready   = w_grant;
  assign lane_valid  = r_lane_valid;
  assign lane_tag    = r_lane_tag;
  assign lane_data   = r_lane_data;
  assign lane_src    = r_lane_src;
  assign dup_tag_err = r_dup_tag_err;

endmodule
